// File: rtl/cbus_line_master.sv
// rtl/cbus_line_master.sv - CBus line/uncached burst initiator with line buffers
// Optional protocol checker: define CBUS_LINE_MASTER_CHECK_EN to enable err.
package cbus_pkg;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [1:0] cburst_t;
  localparam cburst_t BURST_FIXED = 2'd0;
  localparam cburst_t BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    cburst_t     burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_line_master
  import cbus_pkg::*;
#(
  parameter int WORDS      = 8,
  parameter int ADDR_ALIGN = $clog2(WORDS) + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_write,
  input  logic                  req_uncached,
  input  logic [63:0]           req_addr,
  input  logic [2:0]            req_size,
  input  logic [7:0]            req_strobe,
  input  logic [64*WORDS-1:0]   req_wline,
  output logic                  resp_valid,
  output logic [64*WORDS-1:0]   resp_rline,
  output cbus_req_t             oreq,
  input  cbus_resp_t            oresp,
  output logic                  err
);
  localparam int BW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  cbus_req_t              oreq_q, oreq_d;
  logic [WORDS-1:0][63:0] wbuf_q, wbuf_d;
  logic [WORDS-1:0][63:0] rbuf_q, rbuf_d;
  logic                   accept;
  logic                   beat_done;
  logic                   burst_end;

  assign accept    = (state_q == IDLE) && req_valid;
  assign beat_done = (state_q == BUSY) && oresp.ready;
  assign burst_end = beat_done && oresp.last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (burst_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at accept and held for the whole burst.
  always_comb begin
    oreq_d = oreq_q;
    beat_d = beat_q;
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    if (accept) begin
      oreq_d.valid    = 1'b1;
      oreq_d.is_write = req_is_write;
      oreq_d.data     = '0;
      if (req_uncached) begin
        oreq_d.addr   = req_addr;
        oreq_d.burst  = BURST_FIXED;
        oreq_d.len    = 8'd0;
        oreq_d.size   = req_size;
        oreq_d.strobe = req_is_write ? req_strobe : 8'h00;
      end else begin
        oreq_d.addr   = req_addr & ~((64'd1 << ADDR_ALIGN) - 64'd1);
        oreq_d.burst  = BURST_INCR;
        oreq_d.len    = 8'(WORDS - 1);
        oreq_d.size   = MSIZE8;
        oreq_d.strobe = 8'hFF;
      end
      wbuf_d = req_wline;
      beat_d = '0;
    end
    if (beat_done) begin
      if (!oreq_q.is_write) rbuf_d[beat_q] = oresp.data;
      beat_d = beat_q + 1'b1;
      if (oresp.last) begin
        oreq_d.valid = 1'b0;
        beat_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreq_q <= '0;
      beat_q <= '0;
    end else begin
      oreq_q <= oreq_d;
      beat_q <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    rbuf_q <= rbuf_d;
  end

  // Write data is gated by valid so the bus reads all-zero while idle.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_rline = rbuf_q;
    oreq       = oreq_q;
    oreq.data  = oreq_q.valid ? wbuf_q[beat_q] : 64'd0;
  end

`ifdef CBUS_LINE_MASTER_CHECK_EN
  logic err_q, err_d;
  logic last_bad, wrap_bad;

  always_comb begin
    last_bad = burst_end &&
               ((oreq_q.burst == BURST_INCR) ? (beat_q != BW'(WORDS - 1)) : (beat_q != '0));
    wrap_bad = beat_done && !oresp.last && (beat_q == BW'(WORDS - 1));
    err_d    = err_q | last_bad | wrap_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (last_bad) $error("cbus_line_master: last on unexpected beat %0d", beat_q);
      if (wrap_bad) $error("cbus_line_master: beat counter wrapped without last");
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cbus_line_master.sv
// tb/tb_cbus_line_master.sv - randomized self-checking bench for cbus_line_master
module tb_cbus_line_master;
  import cbus_pkg::*;

  localparam int WORDS = 8;
  localparam int ALIGN = $clog2(WORDS) + 3;
  typedef logic [WORDS-1:0][63:0] line_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_is_write = 1'b0;
  logic       req_uncached = 1'b0;
  logic [63:0] req_addr = '0;
  logic [2:0] req_size = '0;
  logic [7:0] req_strobe = '0;
  line_t      req_wline = '0;
  logic       resp_valid;
  line_t      resp_rline;
  cbus_req_t  oreq;
  cbus_resp_t oresp = '0;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  line_t exp_rline;
  bit [WORDS-1:0] rline_known = '0;

  cbus_line_master #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_uncached(req_uncached),
    .req_addr(req_addr), .req_size(req_size), .req_strobe(req_strobe),
    .req_wline(req_wline),
    .resp_valid(resp_valid), .resp_rline(resp_rline),
    .oreq(oreq), .oresp(oresp), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < WORDS; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after resp_valid.
  task automatic do_txn(input bit wr, input bit unc, input logic [63:0] addr,
                        input logic [2:0] sz, input logic [7:0] strb, input line_t wl,
                        input line_t rd, input int mode, input string name,
                        output int lat, output int acc_cyc);
    cbus_req_t exp, got;
    int nb, done_b, c, endc;
    bit rdy;
    exp = '0;
    exp.valid = 1'b1;
    exp.is_write = wr;
    if (unc) begin
      exp.addr = addr; exp.burst = BURST_FIXED; exp.len = 8'd0;
      exp.size = sz; exp.strobe = wr ? strb : 8'h00;
    end else begin
      exp.addr = (addr >> ALIGN) << ALIGN; exp.burst = BURST_INCR;
      exp.len = 8'(WORDS - 1); exp.size = MSIZE8; exp.strobe = 8'hFF;
    end
    nb = unc ? 1 : WORDS;
    lat = -1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_is_write = wr; req_uncached = unc; req_addr = addr;
    req_size = sz; req_strobe = strb; req_wline = wl;
    oresp = '0;
    @(posedge clk);
    acc_cyc = cyc;
    done_b = 0; endc = -1; c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (c > 400) begin
        checks++; errors++;
        $display("FAIL %s timeout: no resp_valid after %0d cycles", name, c);
        break;
      end
      if (resp_valid === 1'b1 && lat < 0) lat = c;
      if (endc < 0 || c < endc) begin
        checks++;
        if (oreq.valid !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_ctl c=%0d: valid=%b ready=%b resp=%b want 1 0 0",
                   name, c, oreq.valid, req_ready, resp_valid);
        end
        got = oreq; got.data = '0;
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL %s oreq_fields c=%0d: got %h want %h", name, c, got, exp);
        end
        if (wr) begin
          checks++;
          if (oreq.data !== wl[done_b]) begin
            errors++;
            $display("FAIL %s wdata beat %0d: got %h want %h", name, done_b, oreq.data, wl[done_b]);
          end
        end
      end else if (c == endc) begin
        checks++;
        if (resp_valid !== 1'b1 || oreq.valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done: resp=%b valid=%b want 1 0", name, resp_valid, oreq.valid);
        end
        if (!wr) begin
          if (unc) begin exp_rline[0] = rd[0]; rline_known[0] = 1'b1; end
          else begin exp_rline = rd; rline_known = '1; end
        end
        for (int i = 0; i < WORDS; i++) begin
          if (rline_known[i]) begin
            checks++;
            if (resp_rline[i] !== exp_rline[i]) begin
              errors++;
              $display("FAIL %s rline[%0d]: got %h want %h", name, i, resp_rline[i], exp_rline[i]);
            end
          end
        end
      end else begin
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done: resp=%b ready=%b err=%b want 0 1 0",
                   name, resp_valid, req_ready, err);
        end
        req_valid = 1'b0;
        break;
      end
      // Responder and ignored upstream noise for the next edge
      if (endc < 0) begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ((c - 1) % 2) == 0;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        oresp.ready = rdy;
        oresp.data  = rdy ? rd[done_b] : {$urandom, $urandom};
        oresp.last  = rdy ? (done_b == nb - 1) : 1'($urandom_range(0, 1));
        if (rdy) begin
          done_b++;
          if (done_b == nb) endc = c + 1;
        end
      end else begin
        oresp = '0;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_is_write = 1'($urandom_range(0, 1));
      req_uncached = 1'($urandom_range(0, 1));
      req_addr = {$urandom, $urandom};
      req_strobe = 8'($urandom);
      req_wline = rand_line();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || oreq !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b resp=%b oreq=%h err=%b want 1 0 0 0",
               req_ready, resp_valid, oreq, err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_refill();
    line_t rd, wl;
    int lat, acc;
    for (int i = 0; i < WORDS; i++) rd[i] = 64'h1000 + 64'(i);
    wl = rand_line();
    do_txn(1'b0, 1'b0, 64'h8000_1238, 3'd0, 8'h00, wl, rd, 0, "refill", lat, acc);
    checks++;
    if (lat !== WORDS + 1) begin
      errors++; $display("FAIL refill_latency: got %0d want %0d", lat, WORDS + 1);
    end
  endtask

  task automatic test_writeback_toggle();
    line_t wl;
    int lat, acc;
    wl = rand_line();
    do_txn(1'b1, 1'b0, {$urandom, $urandom}, 3'd0, 8'h00, wl, rand_line(), 1,
           "wb_toggle", lat, acc);
    checks++;
    if (lat !== 2 * WORDS) begin
      errors++; $display("FAIL wb_toggle_latency: got %0d want %0d", lat, 2 * WORDS);
    end
  endtask

  task automatic test_uncached();
    line_t rd;
    int lat, acc;
    do_txn(1'b1, 1'b1, 64'h4060_0008, MSIZE4, 8'h0F, rand_line(), rand_line(), 0,
           "unc_write", lat, acc);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL unc_write_latency: got %0d want 2", lat);
    end
    rd = rand_line();
    rd[0] = 64'h2A;
    do_txn(1'b0, 1'b1, 64'h3800_bff8, MSIZE8, 8'hFF, rand_line(), rd, 0,
           "unc_read", lat, acc);
  endtask

  task automatic test_back_to_back();
    int lat, acc0, acc1;
    do_txn(1'b1, 1'b1, {$urandom, $urandom}, MSIZE2, 8'h03, rand_line(), rand_line(), 0,
           "b2b_0", lat, acc0);
    for (int k = 1; k < 4; k++) begin
      do_txn(1'($urandom_range(0, 1)), 1'b1, {$urandom, $urandom}, MSIZE1, 8'h01,
             rand_line(), rand_line(), 0, "b2b_n", lat, acc1);
      checks++;
      if (acc1 - acc0 !== 3) begin
        errors++; $display("FAIL b2b_spacing: got %0d want 3", acc1 - acc0);
      end
      acc0 = acc1;
    end
  endtask

  task automatic test_reset_mid_burst();
    line_t rd;
    int lat, acc;
    rd = rand_line();
    req_valid = 1'b1; req_is_write = 1'b0; req_uncached = 1'b0;
    req_addr = {$urandom, $urandom}; req_wline = rand_line();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = rd[k];
      @(negedge clk);
    end
    checks++;
    if (oreq.valid !== 1'b1) begin
      errors++; $display("FAIL mid_burst_busy: valid=%b want 1", oreq.valid);
    end
    oresp = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (oreq.valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_burst_reset: valid=%b ready=%b resp=%b want 0 1 0",
               oreq.valid, req_ready, resp_valid);
    end
    for (int k = 0; k < 3; k++) begin exp_rline[k] = rd[k]; rline_known[k] = 1'b1; end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL post_reset_idle: resp=%b ready=%b want 0 1", resp_valid, req_ready);
      end
    end
    do_txn(1'b0, 1'b0, {$urandom, $urandom}, 3'd0, 8'h00, rand_line(), rand_line(), 2,
           "post_reset_refill", lat, acc);
  endtask

  task automatic test_random();
    int lat, acc;
    for (int k = 0; k < 10; k++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             3'($urandom_range(0, 3)), 8'($urandom), rand_line(), rand_line(),
             $urandom_range(0, 2), "random", lat, acc);
    end
  endtask

`ifdef CBUS_LINE_MASTER_CHECK_EN
  task automatic test_check_err();
    req_valid = 1'b1; req_is_write = 1'b0; req_uncached = 1'b0; req_addr = 64'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      oresp.ready = 1'b1; oresp.last = (k == 5); oresp.data = 64'(k);
      @(negedge clk);
    end
    oresp = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_reset: got %b want 0", err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_refill();
    test_writeback_toggle();
    test_uncached();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
`ifdef CBUS_LINE_MASTER_CHECK_EN
    test_check_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/cbus_line_master.md
Name: cbus_line_master

Overview:
- CBus initiator that turns cache line-refill, line-writeback and single-word uncached requests into CBus bursts.
- Sits between the D-cache/I-cache miss logic and the CBus arbiter. The CBus-to-SRAM/MMIO responder is at the far end.
- Buffers a whole line on each side: the write line is captured on accept, and read beats are assembled into a line.

Parameters:
- WORDS, 8, 64-bit words per cache line; 2..16, power of two; burst len = WORDS-1
- ADDR_ALIGN, $clog2(WORDS)+3, low address bits cleared for line requests

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  upstream request accepted when valid&ready
- req_is_write  in  1  1 = writeback, 0 = refill
- req_uncached  in  1  1 = single-word FIXED access
- req_addr  in  64  byte address
- req_size  in  3  msize_t; uncached only
- req_strobe  in  8  byte strobe; uncached write only
- req_wline  in  64*WORDS  write line; word 0 = lowest address; uncached uses word 0
- resp_valid  out  1  one-cycle completion pulse
- resp_rline  out  64*WORDS  read line; uncached read in word 0
- oreq  out  cbus_req_t  valid, is_write, size, addr, strobe, data, len, burst
- oresp  in  cbus_resp_t  ready, last, data
- err  out  1  sticky protocol error; see Optional Feature

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, oreq all zero (valid=0), req_ready=1, resp_valid=0, beat=0, err=0.
  - rbuf/wbuf are not reset.
- States:
  - IDLE: req_ready=1. On req_valid, capture the request, load wbuf from req_wline, and go to BUSY on the next edge.
  - BUSY: req_ready=0. oreq is held stable, with valid=1, for the whole burst.
  - DONE: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- oreq fields are registered; there is no combinational path from req_* to oreq.
- Line request (req_uncached=0):
  - addr = req_addr with bits [ADDR_ALIGN-1:0] cleared.
  - burst=INCR, size=MSIZE8, len=WORDS-1, strobe=8'hFF.
- Uncached request:
  - addr = req_addr unmodified, burst=FIXED, len=0.
  - size=req_size, strobe=req_strobe (0 for reads).
- Beat handshake:
  - A beat completes on any BUSY cycle with oresp.ready=1.
  - beat (width $clog2(WORDS)) increments on each completed beat and wraps to 0 after WORDS-1.
  - The responder generates the address increment; oreq.addr stays at the base.
- Write path: oreq.data = wbuf[beat] combinationally from the beat register, so the data changes the cycle after each completed beat.
- Read path: on each completed beat, rbuf[beat] <= oresp.data. resp_rline = rbuf and holds until the next read completes.
- Termination:
  - A beat with oresp.ready & oresp.last ends the burst: BUSY -> DONE, oreq.valid drops on the same edge, beat <= 0.
  - Termination on last is authoritative; the beat count does not force an end.
- Boundary cases:
  - oresp.ready=0 stalls indefinitely with no timeout.
  - oresp.last while ready=0 is ignored.
  - req_valid during BUSY/DONE is ignored (req_ready=0).
  - Back-to-back requests: a new request is accepted in the IDLE cycle following DONE. Minimum spacing is 3 cycles per uncached access.
  - Reset mid-burst: oreq.valid drops asynchronously, the state machine returns to IDLE, and no resp_valid is issued.
- Latency: accept edge -> oreq.valid on the next cycle. For a zero-wait responder, resp_valid arrives WORDS+1 cycles after accept (line) or 2 cycles after accept (uncached).

Optional Feature:
- Macro: CBUS_LINE_MASTER_CHECK_EN.
- Defined:
  - err sets, and stays set until reset, if last arrives on a beat other than WORDS-1 for INCR or other than 0 for FIXED.
  - err also sets if the beat counter wraps without last being seen.
  - Each error also prints $error in simulation.
- Undefined: err is tied to 0 and no checker logic is generated.

Test Plan:
- Refill, zero-wait responder, WORDS=8, req_addr=0x8000_1238:
  - oreq.addr=0x8000_1200, len=7, burst=INCR.
  - Read data 0x1000+i arrives on beat i.
  - resp_valid is asserted exactly 9 cycles after accept, with rline word i = 0x1000+i.
- Writeback with ready toggling 1,0,1,0:
  - oreq.data advances only after ready beats.
  - The responder sees words 0..7 in order, and resp_valid follows the last beat.
- Uncached 4-byte write, addr=0x4060_0008, strobe=8'h0F:
  - oreq shows burst=FIXED, len=0, size=MSIZE4, strobe=8'h0F.
  - With ready=1 and last=1, resp_valid arrives 2 cycles after accept.
- Uncached read of 0x3800_bff8 returning 0x2A: resp_rline word0=0x2A.
- Async reset at beat 3 of a refill:
  - oreq.valid=0 immediately and state is IDLE.
  - No resp_valid; the next request completes normally.
- With CBUS_LINE_MASTER_CHECK_EN, responder asserts last on beat 5 of an INCR len 7: err=1 and stays 1 until reset.
